// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    FE_RUN,
    FE_FAULT
  } fe_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one aligned fetch per cycle and tracks the registered memory response.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             fe_rd_en,
  output logic [WIDTH-1:0] fe_rd_addr,
  input  logic [WIDTH-1:0] fe_rd_data,
  output logic [WIDTH-1:0] o_instr,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_valid,
  output logic             o_misalign,
  output logic [WIDTH-1:0] o_fault_pc
);

  fe_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [WIDTH-1:0] fault_pc_q, fault_pc_d;
  logic             resp_valid_q, resp_valid_d;
  logic             rd_en;
  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] redir_tgt;
  logic             redir_bad;

  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    redir_tgt = redirect_pc;
    redir_bad = |redirect_pc[1:0];
`else
    redir_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
    redir_bad = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    fault_pc_d   = fault_pc_q;
    rd_en        = 1'b0;
    rd_addr      = pc_q;
    // Halt freezes everything, including a pending redirect, which execute keeps asserted.
    if (!halt) begin
      if (redirect_en) begin
        if (redir_bad) begin
          resp_valid_d = 1'b0;
          state_d      = FE_FAULT;
          fault_pc_d   = redirect_pc;
        end else begin
          rd_en        = 1'b1;
          rd_addr      = redir_tgt;
          pc_d         = redir_tgt + WIDTH'(INSTR_BYTES);
          resp_pc_d    = redir_tgt;
          resp_valid_d = 1'b1;
          state_d      = FE_RUN;
        end
      end else if (state_q == FE_RUN && !stall) begin
        rd_en        = 1'b1;
        rd_addr      = pc_q;
        resp_pc_d    = pc_q;
        resp_valid_d = 1'b1;
        pc_d         = pc_q + WIDTH'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FE_RUN;
      pc_q         <= RESET_PC;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      fault_pc_q   <= fault_pc_d;
    end
  end

  // Stalls keep the response alive because the memory only updates its read data on a request.
  always_comb begin
    fe_rd_en   = rd_en & reset;
    fe_rd_addr = rd_addr;
    o_valid    = resp_valid_q & ~redirect_en & (state_q == FE_RUN);
    o_instr    = o_valid ? fe_rd_data : WIDTH'(NOP_INSTR);
    o_pc       = resp_pc_q;
    o_misalign = (state_q == FE_FAULT);
    o_fault_pc = fault_pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model queues expected (pc, instr) pairs, a monitor pops them on consumption.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, halt, stall, redirect_en;
  logic [31:0] redirect_pc;
  logic        fe_rd_en;
  logic [31:0] fe_rd_addr;
  logic [31:0] fe_rd_data = '0;
  logic [31:0] o_instr, o_pc, o_fault_pc;
  logic        o_valid, o_misalign;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .halt(halt), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .fe_rd_en(fe_rd_en), .fe_rd_addr(fe_rd_addr), .fe_rd_data(fe_rd_data),
    .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid),
    .o_misalign(o_misalign), .o_fault_pc(o_fault_pc)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // Memory with one-cycle registered read; data only changes on a request.
  always @(posedge clk) if (fe_rd_en) fe_rd_data <= word_at(fe_rd_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sbq[$];

  int errors = 0, checks = 0, consumed = 0;

  logic [31:0] m_pc, m_resp_pc, m_fault_pc;
  bit          m_resp_valid, m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_resp_pc = '0; m_resp_valid = 0; m_fault = 0; m_fault_pc = '0;
    sbq.delete();
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc = a; e.instr = word_at(a);
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && o_valid && !stall && !halt) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got pc %h expected nothing", o_pc);
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", o_pc, e.pc);
        chk("sb_instr", o_instr, e.instr);
        consumed++;
      end
    end
  end

  task automatic step(input bit h, input bit s, input bit r, input logic [31:0] rpc);
    bit          exp_en, exp_valid, bad;
    logic [31:0] exp_addr, tgt;
    halt = h; stall = s; redirect_en = r; redirect_pc = rpc;
    tgt = rpc; bad = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    bad = (rpc[1:0] != 2'b00);
`else
    tgt[1:0] = 2'b00;
`endif
    exp_en = 0; exp_addr = m_pc;
    if (!h && r && !bad) begin exp_en = 1; exp_addr = tgt; end
    else if (!h && !r && !m_fault && !s) begin exp_en = 1; exp_addr = m_pc; end
    exp_valid = m_resp_valid && !r && !m_fault;
    @(negedge clk); #1;
    chk("rd_en", 32'(fe_rd_en), 32'(exp_en));
    if (exp_en) chk("rd_addr", fe_rd_addr, exp_addr);
    chk("valid", 32'(o_valid), 32'(exp_valid));
    chk("instr", o_instr, exp_valid ? word_at(m_resp_pc) : NOP_INSTR);
    chk("pc", o_pc, m_resp_pc);
    chk("misalign", 32'(o_misalign), 32'(m_fault));
    chk("fault_pc", o_fault_pc, m_fault_pc);
    if (!h) begin
      if (r && bad) begin
        sbq.delete(); m_resp_valid = 0; m_fault = 1; m_fault_pc = rpc;
      end else if (r) begin
        sbq.delete(); push(tgt);
        m_resp_pc = tgt; m_pc = tgt + 32'd4; m_resp_valid = 1; m_fault = 0;
      end else if (exp_en) begin
        push(m_pc);
        m_resp_pc = m_pc; m_pc = m_pc + 32'd4; m_resp_valid = 1;
      end
    end
  endtask

  task automatic cycle(input bit h, input bit s, input bit r, input logic [31:0] rpc);
    @(posedge clk); #1;
    step(h, s, r, rpc);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0, 0, '0);
  endtask

  initial begin
    bit          h, s, r;
    logic [31:0] rpc;
    reset = 1'b0; halt = 0; stall = 0; redirect_en = 0; redirect_pc = '0;
    model_reset();
    @(negedge clk); @(negedge clk); #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_rd_en", 32'(fe_rd_en), 32'd0);
    chk("rst_misalign", 32'(o_misalign), 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_fault_pc", o_fault_pc, 32'd0);

    release_reset();
    cycle(0, 0, 0, '0);
    cycle(0, 1, 0, '0);
    cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);
    cycle(0, 0, 1, 32'h40);
    repeat (2) cycle(0, 0, 0, '0);
    cycle(0, 1, 1, 32'h80);
    repeat (2) cycle(0, 0, 0, '0);
    repeat (3) cycle(1, 0, 1, 32'h100);
    cycle(0, 0, 1, 32'h100);
    repeat (2) cycle(0, 0, 0, '0);
    cycle(0, 0, 1, 32'h42);
    repeat (2) cycle(0, 0, 0, '0);
    cycle(0, 0, 1, 32'h80);
    repeat (2) cycle(0, 0, 0, '0);
    cycle(0, 0, 1, 32'hFFFF_FFF8);
    repeat (3) cycle(0, 0, 0, '0);

    // Asynchronous reset between edges.
    @(posedge clk); #3;
    halt = 0; stall = 0; redirect_en = 0;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_rd_en", 32'(fe_rd_en), 32'd0);
    chk("midrst_misalign", 32'(o_misalign), 32'd0);
    chk("midrst_pc", o_pc, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();
    repeat (3) cycle(0, 0, 0, '0);

    for (int i = 0; i < 3000; i++) begin
      h = ($urandom % 10) == 0;
      s = ($urandom % 5) == 0;
      r = ($urandom % 8) == 0;
      rpc = $urandom;
      if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
      cycle(h, s, r, rpc);
    end
    cycle(0, 0, 1, 32'h200);
    repeat (2) cycle(0, 0, 0, '0);

    chk("consumed_enough", 32'(consumed > 500), 32'd1);
    chk("sb_depth", 32'(sbq.size()), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core, directly upstream of the memory block's fetch read port. Owns the program counter, issues one word-aligned fetch per cycle, and absorbs the memory's one-cycle registered read latency. Presents instruction, PC and valid to decode, and handles decode back-pressure, execute-stage redirects and the global halt.

## Interface
- WIDTH, 32: address and instruction width.
- RESET_PC, 0: PC loaded on reset; must be word-aligned.

- clk  in  1  single clock; the memory's rd_clk is driven from the same net.
- reset  in  1  asynchronous, active-low reset.
- halt  in  1  global freeze; same signal as the memory's halt.
- stall  in  1  decode back-pressure; hold the current output.
- redirect_en  in  1  branch/jump taken in execute.
- redirect_pc  in  WIDTH  redirect target byte address.
- fe_rd_en  out  1  fetch request to memory.
- fe_rd_addr  out  WIDTH  byte address; bits [1:0] always 0.
- fe_rd_data  in  WIDTH  memory response, valid the cycle after the request.
- o_instr  out  WIDTH  instruction to decode; NOP (0x00000013) when o_valid=0.
- o_pc  out  WIDTH  address of o_instr.
- o_valid  out  1  o_instr/o_pc are a live instruction.
- o_misalign  out  1  misaligned-redirect fault; see Configuration.
- o_fault_pc  out  WIDTH  target that caused the fault.

## Operation
- State: pc (next issue address), resp_valid, resp_pc, fsm ∈ {FE_RUN, FE_FAULT}.
- The following priority is evaluated each cycle, with reset deasserted:
  - halt=1: all registers hold; fe_rd_en=0; redirect_en is ignored, and execute holds it until halt drops.
  - redirect_en=1 (target aligned): fe_rd_en=1, fe_rd_addr=redirect_pc; pc<=redirect_pc+4; resp_pc<=redirect_pc; resp_valid<=1; fsm<=FE_RUN. Redirect beats stall.
  - fsm=FE_FAULT: fe_rd_en=0; registers hold.
  - stall=1: fe_rd_en=0; pc, resp_pc and resp_valid hold. The memory does not update fe_rd_data without fe_rd_en, so the response is preserved without a skid register.
  - Otherwise: fe_rd_en=1, fe_rd_addr=pc; resp_pc<=pc; resp_valid<=1; pc<=pc+4.
- Outputs:
  - o_valid = resp_valid & ~redirect_en & (fsm==FE_RUN). The wrong-path instruction presented during a redirect cycle is suppressed.
  - o_instr = o_valid ? fe_rd_data : NOP.
  - o_pc = resp_pc.
- Arithmetic: pc+4 is modulo 2^WIDTH; 0xFFFFFFFC wraps to 0x0 silently. Address aliasing inside the memory is outside this block's scope.

## Timing
- Reset values, applied asynchronously: pc=RESET_PC, resp_valid=0, resp_pc=0, fsm=FE_RUN, o_fault_pc=0.
- Outputs while reset is asserted: fe_rd_en=0, o_valid=0, o_misalign=0.
- Latency: request in cycle t gives o_valid/o_instr in cycle t+1.
- Throughput: one instruction per cycle when not stalled.
- Redirect penalty at fetch: one bubble (the redirect cycle itself); the target is presented at t+1.
- Reset asserted mid-stream: everything returns to reset values immediately; the first request is issued on the first clk edge after release.
- The halt/stall/redirect paths to fe_rd_en and fe_rd_addr are combinational; there is no combinational path from fe_rd_data to fe_rd_en.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]≠0 issues no fetch and clears resp_valid.
  - It sets fsm<=FE_FAULT and o_fault_pc<=redirect_pc.
  - o_misalign = (fsm==FE_FAULT).
  - FE_FAULT exits only on an aligned redirect; a further misaligned redirect updates o_fault_pc and stays in FE_FAULT.
- FETCH_MISALIGN_TRAP_EN undefined:
  - redirect_pc[1:0] are treated as 00.
  - FE_FAULT is unreachable; o_misalign ties to 0 and o_fault_pc to 0.

## Structure
- Shared package fetch_pkg holds:
  - enum fe_state_t {FE_RUN, FE_FAULT}
  - INSTR_BYTES=4
  - NOP_INSTR=32'h00000013
- No sub-module; the PC register, response tracking and FSM form one module of about 150–200 lines.

## Test plan
- Reset release, RESET_PC=0, no stall: fe_rd_addr runs 0x0, 0x4, 0x8; o_valid=1 from the next cycle with o_pc=0x0 and o_instr=rom[0], then one word per cycle.
- stall=1 for 2 cycles while o_pc=0x4:
  - o_pc=0x4 and o_instr stay constant; fe_rd_en=0.
  - After release, the next request is 0x8 with no duplicate or skipped PC.
- redirect_en=1, redirect_pc=0x40 while o_pc=0x8:
  - o_valid=0 that cycle; fe_rd_addr=0x40; the next cycle gives o_pc=0x40.
  - 0xC is never presented.
  - Repeat with stall=1 in the same cycle: same result.
- halt=1 for 3 cycles with redirect_en=1:
  - No register change; fe_rd_en=0.
  - Once halt drops, the held redirect takes effect.
- reset pulled low mid-stream between edges: o_valid and fe_rd_en drop to 0 immediately; after release, fetch restarts at RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x42:
  - o_misalign=1, o_fault_pc=0x42, o_valid=0, fe_rd_en=0.
  - A redirect to 0x80 clears the fault and gives o_pc=0x80 one cycle later.
  - Without the macro, the same stimulus fetches 0x40.
